// File: rtl/mux_stream_nxw.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// Fixed-priority or round-robin arbitration; packet lock keeps multi-beat packets contiguous.
module mux_stream_nxw #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic [SEL_W-1:0] rr_q, rr_d;
    logic [WIDTH-1:0] data_d;
    logic             last_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;

    logic             load;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gdata;
    logic             glast;

    // Grant selection; loops run from lowest to highest priority so the last hit wins
    always_comb begin : grant_c
        int unsigned idx;
        idx     = 0;
        load    = !out_valid || out_ready;
        gnt_vld = 1'b0;
        gnt     = '0;
        if (load) begin
            if (state_q == ST_LOCKED) begin
                if (in_valid[lock_q]) begin
                    gnt_vld = 1'b1;
                    gnt     = lock_q;
                end
            end else if (RR_MODE != 0) begin
                for (int unsigned k = CHANNELS; k >= 1; k--) begin
                    idx = 32'(rr_q) + k;
                    if (idx >= CHANNELS) idx = idx - CHANNELS;
                    if (in_valid[SEL_W'(idx)]) begin
                        gnt_vld = 1'b1;
                        gnt     = SEL_W'(idx);
                    end
                end
            end else begin
                for (int unsigned k = CHANNELS; k >= 1; k--) begin
                    if (in_valid[SEL_W'(k - 1)]) begin
                        gnt_vld = 1'b1;
                        gnt     = SEL_W'(k - 1);
                    end
                end
            end
        end
    end

    // Granted channel payload and one-hot accept
    always_comb begin
        gdata    = '0;
        glast    = 1'b0;
        in_ready = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (gnt == SEL_W'(c)) begin
                gdata = in_data[c*WIDTH +: WIDTH];
                glast = in_last[c];
            end
            in_ready[c] = gnt_vld && (gnt == SEL_W'(c));
        end
    end

    // Next state for lock FSM, round-robin pointer and output register
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        data_d  = out_data;
        last_d  = out_last;
        sel_d   = out_sel;
        valid_d = out_valid;
        if (gnt_vld) begin
            data_d  = gdata;
            last_d  = glast;
            sel_d   = gnt;
            valid_d = 1'b1;
            if (RR_MODE != 0) rr_d = gnt;
            case (state_q)
                ST_IDLE: begin
                    if (!glast) begin
                        state_d = ST_LOCKED;
                        lock_d  = gnt;
                    end
                end
                ST_LOCKED: begin
                    if (glast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lock_q    <= '0;
            rr_q      <= SEL_W'(CHANNELS - 1);
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            out_data  <= data_d;
            out_last  <= last_d;
            out_sel   <= sel_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux_stream_nxw.sv
// Scoreboard bench for mux_stream_nxw: directed scenarios plus randomized traffic
// against a queue-based arbitration model.
module tb_mux_stream_nxw #(parameter int RR = 1);

    localparam int W = 16;
    localparam int C = 4;

    typedef struct packed { logic last; logic [W-1:0] data; } beat_t;
    typedef struct packed { logic [1:0] sel; logic last; logic [W-1:0] data; } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [C*W-1:0] in_data = '0;
    logic [C-1:0]   in_valid = '0;
    logic [C-1:0]   in_last = '0;
    logic [C-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    beat_t srcq [C][$];
    exp_t  sbq [$];

    // reference model state
    int m_rr = C - 1;
    int m_lock_ch = 0;
    bit m_locked = 0;
    bit m_full = 0;
    int m_pend = 0;

    mux_stream_nxw #(.WIDTH(W), .CHANNELS(C), .RR_MODE(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the arbitration rules pick from the valid set
    function automatic int pick(input logic [C-1:0] v);
        if (m_locked) return v[m_lock_ch] ? m_lock_ch : -1;
        if (RR != 0) begin
            for (int k = 1; k <= C; k++) if (v[(m_rr + k) % C]) return (m_rr + k) % C;
        end else begin
            for (int ch = 0; ch < C; ch++) if (v[ch]) return ch;
        end
        return -1;
    endfunction

    task automatic push_beat(input int c, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        srcq[c].push_back(b);
    endtask

    task automatic drive_inputs(input logic [C-1:0] mask);
        for (int c = 0; c < C; c++) begin
            if (mask[c] && srcq[c].size() > 0) begin
                in_valid[c]         = 1'b1;
                in_data[c*W +: W]   = srcq[c][0].data;
                in_last[c]          = srcq[c][0].last;
            end else begin
                in_valid[c]         = 1'b0;
                in_data[c*W +: W]   = W'($urandom);
                in_last[c]          = 1'($urandom);
            end
        end
    endtask

    // One clock of stimulus; the model predicts grant and pushes the expected beat
    task automatic cycle(input logic [C-1:0] mask, input bit ordy);
        int g;
        bit load;
        logic [C-1:0] exp_rdy;
        beat_t b;
        exp_t e;
        @(negedge clk);
        out_ready = ordy;
        drive_inputs(mask);
        #1;
        load = !m_full || ordy;
        g = load ? pick(in_valid) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        m_pend = 0;
        if (g >= 0) begin
            b = srcq[g].pop_front();
            e.sel = 2'(g);
            e.last = b.last;
            e.data = b.data;
            sbq.push_back(e);
            m_pend = 1;
            if (RR != 0) m_rr = g;
            if (!m_locked && !b.last) begin
                m_locked = 1;
                m_lock_ch = g;
            end else if (m_locked && b.last) begin
                m_locked = 0;
            end
            m_full = 1;
        end else if (load) begin
            m_full = 0;
        end
    endtask

    task automatic do_reset(input int n, input logic [C-1:0] mask);
        @(negedge clk);
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = mask;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        sbq.delete();
        m_rr = C - 1; m_locked = 0; m_full = 0; m_pend = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = mask;
            #1;
            chk("rst_hold_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b1);
    endtask

    // Monitor: just before each rising edge compare the presented beat with the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #9;
            if (rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(sbq.size() > m_pend));
                if (out_valid && sbq.size() > 0) begin
                    e = sbq[0];
                    chk("beat", 32'({out_sel, out_last, out_data}), 32'(e));
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        // 1: reset with all channels requesting, then strict rotation
        for (int c = 0; c < C; c++) begin
            push_beat(c, W'(16'h1000 + c), 1'b1);
            push_beat(c, W'(16'h1100 + c), 1'b1);
        end
        do_reset(3, 4'b1111);
        for (int i = 0; i < 9; i++) cycle(4'b1111, 1'b1);
        drain(2);

        // 2: two requesters held valid, single-beat packets
        for (int i = 0; i < 4; i++) begin
            push_beat(1, W'(16'h2100 + i), 1'b1);
            push_beat(3, W'(16'h2300 + i), 1'b1);
        end
        for (int i = 0; i < 8; i++) cycle(4'b1010, 1'b1);
        drain(2);

        // 3: ch2 3-beat packet with a 2-cycle gap; ch0 must not interleave
        push_beat(2, 16'hA000, 1'b0);
        push_beat(2, 16'hA001, 1'b0);
        push_beat(2, 16'hA002, 1'b1);
        for (int i = 0; i < 4; i++) push_beat(0, W'(16'h3000 + i), 1'b1);
        cycle(4'b0100, 1'b1);
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'b0101, 1'b1);
        drain(2);

        // 4: backpressure holds the output beat
        push_beat(1, 16'hBEEF, 1'b1);
        push_beat(0, 16'h4000, 1'b1);
        cycle(4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        drain(2);

        // 5: reset in the middle of a ch1 packet
        for (int i = 0; i < 4; i++) push_beat(1, W'(16'h5100 + i), 1'(i == 3));
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        do_reset(1, 4'b0000);
        srcq[1].delete();
        push_beat(3, 16'h5300, 1'b1);
        cycle(4'b1000, 1'b1);
        drain(2);

        // 6: back-to-back throughput from ch0
        for (int i = 0; i < 8; i++) push_beat(0, W'(i), 1'(i == 7));
        for (int i = 0; i < 8; i++) cycle(4'b0001, 1'b1);
        drain(2);

        // randomized traffic with random backpressure
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < C; c++)
                if (srcq[c].size() == 0)
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                        push_beat(c, W'($urandom), 1'($urandom_range(0, 9) < 3));
            cycle(C'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < C; c++) srcq[c].delete();
        m_locked = 0;
        do_reset(1, 4'b0000);
        drain(3);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
